aes_round_sched: RTL and testbench
==================================

Name: aes_round_sched

Overview:
- Iterative AES encryption round sequencer. Accepts one 128-bit block and drives the shared SubByte+MixColumn datapath once per round.
- Performs ShiftRows (wiring) before each datapath issue, and AddRoundKey after each datapath return.
- Reads round keys from an external round-key store and returns the ciphertext through a valid/ready handshake.
- Sits between the block-level I/O wrapper and the sb/mc datapath, which carries a last-round mode bit that suppresses MixColumn.

Parameters:
- DATA_WIDTH, 128, state and key width; only 128 is supported.
- NR, 10, number of rounds (10/12/14 legal); sizes the round counter and rk_addr range 0..NR.
- WDOG_CYCLES, 15, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  plaintext block offered.
- in_ready  out  1  scheduler can accept a block.
- in_data  in  128  plaintext; byte 0 = [127:120], column-major, 32 bits per column.
- rk_addr  out  4  round-key index; store returns the key one cycle later.
- rk_data  in  128  round key for the rk_addr of the previous cycle.
- dp_valid  out  1  one-cycle issue pulse to the sb/mc datapath.
- dp_last  out  1  final round; datapath skips MixColumn; qualified by dp_valid.
- dp_state  out  128  ShiftRows(state) sent to the datapath.
- dp_done  in  1  datapath result valid.
- dp_result  in  128  datapath output.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts the ciphertext.
- out_data  out  128  ciphertext.
- sched_err  out  1  one-cycle watchdog abort pulse; constant 0 when the optional feature is compiled out.

Behaviour:
- Reset values (asynchronous on rst high): FSM=IDLE, round=0, state=0, rk_addr=0, dp_valid=0, dp_last=0, out_valid=0, sched_err=0. in_ready=1 after reset because it is decoded as FSM==IDLE.
- FSM states: IDLE, ARK0, ISSUE, WAIT, DONE.
- IDLE: in_ready=1. On in_valid, capture in_data, drive rk_addr=0, go to ARK0.
- ARK0: state<=state^rk_data. Set round=1, rk_addr=1, go to ISSUE.
- ISSUE: dp_valid=1 for exactly one cycle, with dp_state=ShiftRows(state) and dp_last=(round==NR). Go to WAIT.
- WAIT: hold rk_addr=round. On dp_done: state<=dp_result^rk_data.
  - If round==NR, go to DONE.
  - Otherwise round<=round+1, rk_addr<=round+1, go to ISSUE.
- DONE: out_valid=1 and out_data=state, both held stable until out_ready. On out_valid&&out_ready, go to IDLE. New input is accepted on the next cycle, so there is no same-cycle turnaround.
- ShiftRows: output row r, column c = input row r, column (c+r) mod 4. Row r of column c is byte 4c+r.
- Latency: with a 1-cycle datapath, accept at cycle 0, each round takes 2 cycles, and out_valid rises at cycle 2+2*NR (cycle 22 for NR=10). A longer datapath latency simply extends WAIT.
- Boundary conditions:
  - dp_done outside WAIT is ignored.
  - in_valid outside IDLE is ignored (in_ready=0).
  - Only one dp_valid is outstanding at any time.
  - round never exceeds NR.
  - rst mid-operation discards the block, returns to IDLE and does not raise out_valid.

Optional Feature:
- Macro: AES_SCHED_WDOG_EN.
- With the macro: a counter clears on entry to WAIT and increments each WAIT cycle without dp_done. On reaching WDOG_CYCLES, pulse sched_err for 1 cycle, discard the block and go to IDLE; out_valid is not raised.
  - dp_done in the same cycle as the limit wins: the round completes normally, with no error.
- Without the macro: no counter, WAIT waits indefinitely, and sched_err is tied to 0.

Decomposition:
- Package aes_pkg: FSM state encoding, NR_AES128/192/256 constants (10/12/14), byte-index helper, shift_rows function.
- One sub-module, aes_shift_rows: purely combinational 128-bit permutation, reused later by the decrypt path (inverse mode).

Test Plan:
- FIPS-197 App. B vector: in_data=3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c preloaded as 11 expanded round keys, bench datapath model with 1-cycle latency -> out_data=3925841d02dc09fbdc118597196a0b32 at cycle 22; dp_valid pulses exactly 10 times; dp_last is high only on the 10th.
- Datapath latency randomized 1..8 cycles, same vector -> same ciphertext; spurious dp_done in IDLE/ISSUE has no effect.
- out_ready held low 5 cycles -> out_valid and out_data stable; in_ready stays 0; accept on the 6th cycle, then a back-to-back second block is accepted the following cycle.
- rst asserted during round 4 WAIT -> all outputs at reset values immediately; the next block encrypts correctly.
- With AES_SCHED_WDOG_EN, dp_done withheld in round 3 -> sched_err pulses after 15 WAIT cycles, FSM returns to IDLE, out_valid never rises. dp_done on exactly cycle 15 -> no error.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: scheduler FSM encoding, round-count constants,
// byte addressing of the column-major 128-bit state and the ShiftRows permutation.
package aes_pkg;

   localparam int NR_AES128 = 10;
   localparam int NR_AES192 = 12;
   localparam int NR_AES256 = 14;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARK0,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } sched_state_e;

   // MSB position of the byte at (column, row); byte 0 sits at [127:120].
   function automatic int byte_hi(input int col, input int row);
      return 127 - 8 * (4 * col + row);
   endfunction

   // inv=0: out(r,c) = in(r,(c+r)%4); inv=1 undoes it for the decrypt path.
   function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int rw = 0; rw < 4; rw++) begin
            if (inv)
               r[byte_hi((c + rw) % 4, rw) -: 8] = s[byte_hi(c, rw) -: 8];
            else
               r[byte_hi(c, rw) -: 8] = s[byte_hi((c + rw) % 4, rw) -: 8];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_shift_rows.sv
// Combinational AES ShiftRows permutation; INV=1 selects InvShiftRows.
module aes_shift_rows
   import aes_pkg::*;
#(
   parameter bit INV = 1'b0
) (
   input  logic [127:0] din,
   output logic [127:0] dout
);

   assign dout = shift_rows(din, INV);

endmodule

// File: rtl/aes_round_sched.sv
// Iterative AES encryption round sequencer: ShiftRows before each datapath issue,
// AddRoundKey on each return. Define AES_SCHED_WDOG_EN to add the WAIT watchdog.
module aes_round_sched
   import aes_pkg::*;
#(
   parameter int DATA_WIDTH  = 128,
   parameter int NR          = NR_AES128,
   parameter int WDOG_CYCLES = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [3:0]            rk_addr,
   input  logic [DATA_WIDTH-1:0] rk_data,
   output logic                  dp_valid,
   output logic                  dp_last,
   output logic [DATA_WIDTH-1:0] dp_state,
   input  logic                  dp_done,
   input  logic [DATA_WIDTH-1:0] dp_result,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  sched_err
);

   localparam logic [3:0] NR_L = 4'(NR);

   sched_state_e          fsm_q, fsm_d;
   logic [3:0]            round_q, round_d;
   logic [3:0]            rk_addr_q, rk_addr_d;
   logic [DATA_WIDTH-1:0] st_q, st_d;
   logic [DATA_WIDTH-1:0] sr_state;

`ifdef AES_SCHED_WDOG_EN
   localparam int             WW       = $clog2(WDOG_CYCLES + 1);
   localparam logic [WW-1:0] WDOG_LIM = WW'(WDOG_CYCLES - 1);
   logic [WW-1:0] wdog_q, wdog_d;
   logic          err_q, err_d;
`endif

   aes_shift_rows #(.INV(1'b0)) u_sr (
      .din  (st_q),
      .dout (sr_state)
   );

   always_comb begin
      fsm_d     = fsm_q;
      round_d   = round_q;
      rk_addr_d = rk_addr_q;
      st_d      = st_q;
`ifdef AES_SCHED_WDOG_EN
      wdog_d    = wdog_q;
      err_d     = 1'b0;
`endif
      case (fsm_q)
         S_IDLE: begin
            // rk_addr is already 0 here so key 0 arrives during ARK0
            if (in_valid) begin
               st_d      = in_data;
               rk_addr_d = 4'd0;
               round_d   = 4'd0;
               fsm_d     = S_ARK0;
            end
         end
         S_ARK0: begin
            st_d      = st_q ^ rk_data;
            round_d   = 4'd1;
            rk_addr_d = 4'd1;
            fsm_d     = S_ISSUE;
         end
         S_ISSUE: begin
            fsm_d = S_WAIT;
`ifdef AES_SCHED_WDOG_EN
            wdog_d = '0;
`endif
         end
         S_WAIT: begin
            if (dp_done) begin
               st_d = dp_result ^ rk_data;
               if (round_q == NR_L) begin
                  fsm_d = S_DONE;
               end else begin
                  round_d   = round_q + 4'd1;
                  rk_addr_d = round_q + 4'd1;
                  fsm_d     = S_ISSUE;
               end
            end
`ifdef AES_SCHED_WDOG_EN
            else if (wdog_q == WDOG_LIM) begin
               // limit reached with no result: drop the block entirely
               err_d     = 1'b1;
               st_d      = '0;
               round_d   = 4'd0;
               rk_addr_d = 4'd0;
               fsm_d     = S_IDLE;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
`endif
         end
         S_DONE: begin
            if (out_ready) begin
               round_d   = 4'd0;
               rk_addr_d = 4'd0;
               fsm_d     = S_IDLE;
            end
         end
         default: fsm_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q     <= S_IDLE;
         round_q   <= 4'd0;
         rk_addr_q <= 4'd0;
         st_q      <= '0;
      end else begin
         fsm_q     <= fsm_d;
         round_q   <= round_d;
         rk_addr_q <= rk_addr_d;
         st_q      <= st_d;
      end
   end

`ifdef AES_SCHED_WDOG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         err_q  <= err_d;
      end
   end

   assign sched_err = err_q;
`else
   assign sched_err = (WDOG_CYCLES < 0);
`endif

   assign in_ready  = (fsm_q == S_IDLE);
   assign rk_addr   = rk_addr_q;
   assign dp_valid  = (fsm_q == S_ISSUE);
   assign dp_last   = dp_valid && (round_q == NR_L);
   assign dp_state  = sr_state;
   assign out_valid = (fsm_q == S_DONE);
   assign out_data  = st_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched using the FIPS-197 App. B vector with a
// behavioural SubBytes/MixColumns datapath and a registered round-key store.
module tb_aes_round_sched;

   localparam logic [127:0] PT       = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT       = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] FIRST_DP = 128'h19f48d08a0c648be9af8e32be93de22a;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [127:0] in_data, rk_data, dp_state, dp_result, out_data;
   logic [3:0]   rk_addr;
   logic         dp_valid, dp_last, dp_done, sched_err;

   aes_round_sched #(.DATA_WIDTH(128), .NR(10), .WDOG_CYCLES(15)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .rk_addr(rk_addr), .rk_data(rk_data), .dp_valid(dp_valid), .dp_last(dp_last),
      .dp_state(dp_state), .dp_done(dp_done), .dp_result(dp_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .sched_err(sched_err)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0;
   int pulses, last_cnt, last_at;
   logic [127:0] first_dp;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00, x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box from first principles: GF(2^8) inverse (a^254) then the affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b = 8'h01;
      for (int i = 0; i < 254; i++) b = gmul(b, a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      return r;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
         r[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
         r[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
         r[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
         r[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
      return r;
   endfunction

   function automatic logic [127:0] round_key(input logic [127:0] key, input int rnd);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
   endfunction

   // round-key store: key for the previous cycle's address
   logic [127:0] rk_mem [0:15];
   always @(posedge clk) rk_data <= rk_mem[rk_addr];

   // datapath model: latency fixed, random 1..8, or overridden on the 3rd issue
   int   fix_lat, lat3, nxt_lat = 1, eff_lat, m_cnt, m_issue;
   logic rand_lat, spur, spur_en, m_done;
   logic [127:0] m_res;

   always @(posedge clk) nxt_lat <= int'($urandom_range(1, 8));
   assign eff_lat   = (lat3 != 0 && m_issue == 2) ? lat3 : (rand_lat ? nxt_lat : fix_lat);
   assign dp_done   = m_done | spur;
   assign dp_result = m_res;

   always @(posedge clk) begin
      if (rst) begin
         m_done  <= 1'b0;
         m_cnt   <= 0;
         m_issue <= 0;
      end else begin
         m_done <= 1'b0;
         if (in_valid && in_ready) m_issue <= 0;
         else if (dp_valid) m_issue <= m_issue + 1;
         if (dp_valid) begin
            m_res <= dp_last ? sub_bytes(dp_state) : mix_cols(sub_bytes(dp_state));
            if (eff_lat <= 1) m_done <= 1'b1;
            else m_cnt <= eff_lat - 1;
         end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_done <= 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      if (dp_valid) begin
         pulses++;
         if (pulses == 1) first_dp = dp_state;
         if (dp_last) begin
            last_cnt++;
            last_at = pulses;
         end
      end
   endtask

   task automatic accept();
      for (int i = 0; i < 50 && !in_ready; i++) step();
      if (spur_en) begin
         spur = 1'b1;
         step();
         spur = 1'b0;
         chki("spur_idle_in_ready", int'(in_ready), 1);
      end
      pulses = 0; last_cnt = 0; last_at = 0; first_dp = '0;
      in_valid = 1'b1;
      in_data  = PT;
      step();
      in_valid = 1'b0;
      chki("busy_in_ready", int'(in_ready), 0);
   endtask

   // k = cycle index (accept cycle = 0) at which out_valid or sched_err is seen
   task automatic run_block(input int max, output int k);
      accept();
      k = 1;
      while (k < max) begin
         sample();
         if (out_valid || sched_err) break;
         spur = spur_en && dp_valid && (pulses == 3);
         step();
         k++;
      end
      spur = 1'b0;
   endtask

   initial begin
      int k;
      rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      spur = 1'b0; spur_en = 1'b0; rand_lat = 1'b0; fix_lat = 1; lat3 = 0;
      for (int r = 0; r < 16; r++) rk_mem[r] = (r <= 10) ? round_key(KEY, r) : '0;
      #2 rst = 1'b1;
      #1;
      chki("rst_in_ready", int'(in_ready), 1);
      chki("rst_out_valid", int'(out_valid), 0);
      chki("rst_dp_valid", int'(dp_valid), 0);
      chki("rst_dp_last", int'(dp_last), 0);
      chki("rst_rk_addr", int'(rk_addr), 0);
      chki("rst_sched_err", int'(sched_err), 0);
      chk("rst_out_data", out_data, '0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // nominal 1-cycle datapath, consumer stalled
      run_block(60, k);
      chki("t1_latency", k, 22);
      chk("t1_data", out_data, CT);
      chki("t1_pulses", pulses, 10);
      chki("t1_last_cnt", last_cnt, 1);
      chki("t1_last_at", last_at, 10);
      chk("t1_first_dp_state", first_dp, FIRST_DP);
      chki("t1_in_ready", int'(in_ready), 0);

      // backpressure: out_ready low for 5 cycles total, then handshake + back-to-back block
      for (int i = 0; i < 4; i++) begin
         step();
         chki("bp_valid", int'(out_valid), 1);
         chk("bp_data", out_data, CT);
         chki("bp_in_ready", int'(in_ready), 0);
      end
      step();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = PT;
      chki("bp_hs_in_ready", int'(in_ready), 0);
      step();
      chki("bp_after_valid", int'(out_valid), 0);
      chki("bp_after_in_ready", int'(in_ready), 1);
      run_block(60, k);
      chki("b2b_latency", k, 22);
      chk("b2b_data", out_data, CT);

      // random datapath latency with spurious dp_done in IDLE and ISSUE
      rand_lat = 1'b1;
      spur_en  = 1'b1;
      run_block(200, k);
      chki("rnd_valid", int'(out_valid), 1);
      chk("rnd_data", out_data, CT);
      chki("rnd_pulses", pulses, 10);
      chki("rnd_last_at", last_at, 10);
      rand_lat = 1'b0;
      spur_en  = 1'b0;

      // reset while waiting in round 4
      fix_lat = 3;
      accept();
      k = 0;
      while (k < 100) begin
         sample();
         if (pulses == 4 && !dp_valid) break;
         step();
         k++;
      end
      chki("mid_round4_reached", pulses, 4);
      rst = 1'b1;
      #1;
      chki("mid_rst_in_ready", int'(in_ready), 1);
      chki("mid_rst_dp_valid", int'(dp_valid), 0);
      chki("mid_rst_out_valid", int'(out_valid), 0);
      chki("mid_rst_rk_addr", int'(rk_addr), 0);
      chk("mid_rst_out_data", out_data, '0);
      @(posedge clk);
      #1 rst = 1'b0;
      fix_lat = 1;
      step();
      chki("post_rst_out_valid", int'(out_valid), 0);
      run_block(60, k);
      chki("post_rst_latency", k, 22);
      chk("post_rst_data", out_data, CT);

`ifdef AES_SCHED_WDOG_EN
      // round 3 result never arrives inside the limit
      lat3 = 16;
      run_block(100, k);
      chki("wd_cycle", k, 22);
      chki("wd_err", int'(sched_err), 1);
      chki("wd_no_out", int'(out_valid), 0);
      chki("wd_idle", int'(in_ready), 1);
      step();
      chki("wd_pulse_len", int'(sched_err), 0);
      // result on exactly the 15th WAIT cycle completes normally
      lat3 = 15;
      run_block(100, k);
      chki("wd_edge_cycle", k, 36);
      chk("wd_edge_data", out_data, CT);
      chki("wd_edge_err", int'(sched_err), 0);
      lat3 = 0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
